// File: rtl/mem_arbiter.sv
// Two-port arbiter sharing one single-ported, fixed-latency memory between
// instruction fetch (read-only) and data access (read/write). Ties are broken
// by alternating grants; busy flags every non-idle cycle so the CPU can stall.
module mem_arbiter #(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 16,
  parameter int MEM_LAT = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [DATA_W-1:0] i_rdata,
  output logic              i_done,
  input  logic              d_req,
  input  logic              d_wr,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_done,
  output logic              mem_enable,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_data_in,
  input  logic [DATA_W-1:0] mem_data_out,
  output logic              busy
);

  localparam int CW = $clog2(MEM_LAT + 1);
  localparam logic [CW-1:0] CNT_TOP = CW'(MEM_LAT - 1);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t            state, state_nx;
  logic [CW-1:0]     cnt;
  logic              sel_d;    // granted port: 1 = data, 0 = fetch
  logic              last_d;   // last granted port: 1 = data, 0 = fetch
  logic              wr_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              grant;
  logic              grant_d;

  // Arbitration and next-state: data wins a tie unless it was served last
  always_comb begin
    grant    = i_req | d_req;
    grant_d  = d_req & (~i_req | ~last_d);
    state_nx = state;
    case (state)
      IDLE:    if (grant) state_nx = ACCESS;
      ACCESS:  if (cnt == '0) state_nx = RESP;
      RESP:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // Request latch, access counter and per-port read data capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= '0;
      sel_d   <= 1'b0;
      last_d  <= 1'b0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      i_rdata <= '0;
      d_rdata <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grant) begin
            sel_d   <= grant_d;
            last_d  <= grant_d;
            addr_q  <= grant_d ? d_addr : i_addr;
            wr_q    <= grant_d & d_wr;
            wdata_q <= grant_d ? d_wdata : '0;
            cnt     <= CNT_TOP;
          end
        end
        ACCESS: begin
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else if (!wr_q) begin
            if (sel_d) d_rdata <= mem_data_out;
            else       i_rdata <= mem_data_out;
          end
        end
        default: ;
      endcase
    end
  end

  // Memory controls and completion pulses decoded from state
  always_comb begin
    mem_enable  = (state == ACCESS);
    mem_wr      = mem_enable & wr_q & (cnt == CNT_TOP);
    mem_addr    = mem_enable ? addr_q  : '0;
    mem_data_in = mem_enable ? wdata_q : '0;
    i_done      = (state == RESP) & ~sel_d;
    d_done      = (state == RESP) &  sel_d;
    busy        = (state != IDLE);
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter (MEM_LAT=4): stimulus pushes expected
// completions, a monitor pops and checks them on every done pulse.
module tb_mem_arbiter;

  localparam int AW  = 16;
  localparam int DW  = 16;
  localparam int LAT = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          i_req = 1'b0;
  logic [AW-1:0] i_addr = '0;
  logic [DW-1:0] i_rdata;
  logic          i_done;
  logic          d_req = 1'b0;
  logic          d_wr = 1'b0;
  logic [AW-1:0] d_addr = '0;
  logic [DW-1:0] d_wdata = '0;
  logic [DW-1:0] d_rdata;
  logic          d_done;
  logic          mem_enable;
  logic          mem_wr;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_data_in;
  logic [DW-1:0] mem_data_out;
  logic          busy;

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(LAT)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_done(i_done),
    .d_req(d_req), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_done(d_done),
    .mem_enable(mem_enable), .mem_wr(mem_wr), .mem_addr(mem_addr),
    .mem_data_in(mem_data_in), .mem_data_out(mem_data_out), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Memory model: read data is only meaningful in the last enable cycle
  logic [DW-1:0] wmem [0:255];
  logic [255:0]  wvalid = '0;
  int            en_run = 0;
  logic [7:0]    ma;
  assign ma = mem_addr[7:0];

  function automatic logic [DW-1:0] init_val(input logic [7:0] a);
    case (a)
      8'h04:   return 16'hA123;
      8'h20:   return 16'h1111;
      8'h30:   return 16'h2222;
      8'h40:   return 16'h4444;
      8'h50:   return 16'h1234;
      8'h60:   return 16'h5678;
      default: return {8'hC0, a};
    endcase
  endfunction

  always @(posedge clk) begin
    if (mem_enable && mem_wr) begin
      wmem[ma]   <= mem_data_in;
      wvalid[ma] <= 1'b1;
    end
    en_run <= mem_enable ? en_run + 1 : 0;
  end

  assign mem_data_out = (mem_enable && en_run == LAT - 1)
                        ? (wvalid[ma] ? wmem[ma] : init_val(ma)) : 16'hDEAD;

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct packed {
    logic          port;   // 1 = data, 0 = fetch
    logic [DW-1:0] data;
  } exp_t;
  exp_t sbq[$];

  task automatic push(input logic port, input logic [DW-1:0] data);
    exp_t e;
    e.port = port;
    e.data = data;
    sbq.push_back(e);
  endtask

  int            wr_cnt = 0;
  int            en_cnt = 0;
  logic [AW-1:0] wr_addr = '0;
  logic [DW-1:0] wr_data = '0;

  // Monitor: checks every completion against the scoreboard, tallies writes
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (mem_enable) en_cnt++;
        if (mem_wr) begin
          wr_cnt++;
          wr_addr = mem_addr;
          wr_data = mem_data_in;
        end
        if (i_done && d_done) begin
          chk("both_done", {i_done, d_done}, 2'b10);
        end else if (i_done || d_done) begin
          if (sbq.size() == 0) begin
            chk("unexpected_done", {i_done, d_done}, 2'b00);
          end else begin
            e = sbq.pop_front();
            chk("done_port", d_done, e.port);
            chk("done_rdata", d_done ? d_rdata : i_rdata, e.data);
          end
        end
      end
    end
  end

  // Wait for a done pulse: want 0 = fetch, 1 = data, 2 = either
  task automatic wait_done(input int want, output int at);
    bit found = 0;
    at = -1;
    for (int n = 0; n < 100 && !found; n++) begin
      @(negedge clk);
      if ((want == 0 && i_done) || (want == 1 && d_done) ||
          (want == 2 && (i_done || d_done))) begin
        found = 1;
        at = cyc;
      end
    end
    if (!found) chk("done_timeout", 0, 1);
  endtask

  int c0, t, td, ti, r, wr0, en1;
  bit hold_ok, seen;

  initial begin
    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_ctl", {i_done, d_done, mem_enable, mem_wr}, 0);
    chk("rst_rdata", {i_rdata, d_rdata}, 0);
    chk("rst_mem", {mem_addr, mem_data_in}, 0);
    @(negedge clk) rst_n = 1'b1;

    // Fetch with fixed latency, no write strobe
    @(posedge clk); #1;
    wr0 = wr_cnt; c0 = cyc;
    i_addr = 16'h0004; i_req = 1'b1;
    push(0, 16'hA123);
    wait_done(0, t);
    i_req = 1'b0;
    chk("fetch_latency", t, c0 + LAT + 1);
    chk("fetch_no_write", wr_cnt - wr0, 0);

    // Store: one write strobe, d_rdata untouched
    @(posedge clk); #1;
    wr0 = wr_cnt;
    d_wr = 1'b1; d_addr = 16'h0010; d_wdata = 16'hBEEF; d_req = 1'b1;
    push(1, 16'h0000);
    wait_done(1, t);
    d_req = 1'b0; d_wr = 1'b0;
    chk("store_wr_count", wr_cnt - wr0, 1);
    chk("store_wr_addr", wr_addr, 16'h0010);
    chk("store_wr_data", wr_data, 16'hBEEF);

    // Tie from reset: data first, fetch one full slot later
    @(negedge clk) rst_n = 1'b0;
    i_addr = 16'h0020; i_req = 1'b1;
    d_addr = 16'h0030; d_req = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    push(1, 16'h2222);
    push(0, 16'h1111);
    wait_done(1, td);
    d_req = 1'b0;
    wait_done(0, ti);
    i_req = 1'b0;
    chk("tie_gap", ti - td, LAT + 2);

    // Both held: grants alternate D,I,D,I starting with D
    @(posedge clk); #1;
    i_req = 1'b1; d_req = 1'b1;
    push(1, 16'h2222); push(0, 16'h1111);
    push(1, 16'h2222); push(0, 16'h1111);
    for (int k = 0; k < 4; k++) wait_done(2, t);
    i_req = 1'b0; d_req = 1'b0;

    // Reset in the cnt==2 access cycle, then a full restart
    @(posedge clk); #1;
    c0 = cyc;
    i_addr = 16'h0040; i_req = 1'b1;
    for (int n = 0; n < 10 && cyc != c0 + 2; n++) @(negedge clk);
    chk("pre_abort_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    chk("abort_ctl", {busy, mem_enable, mem_wr, i_done, d_done}, 0);
    chk("abort_data", {i_rdata, d_rdata, mem_addr, mem_data_in}, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    r = cyc; en1 = en_cnt;
    rst_n = 1'b1;
    push(0, 16'h4444);
    wait_done(0, t);
    i_req = 1'b0;
    chk("restart_latency", t, r + LAT + 1);
    chk("restart_en_cycles", en_cnt - en1, LAT);

    // Load then fetch: d_rdata held, busy drops for one idle cycle
    @(posedge clk); #1;
    d_addr = 16'h0050; d_wr = 1'b0; d_req = 1'b1;
    i_addr = 16'h0060; i_req = 1'b1;
    push(1, 16'h1234);
    push(0, 16'h5678);
    wait_done(1, td);
    d_req = 1'b0;
    @(negedge clk);
    chk("idle_gap_busy", busy, 0);
    hold_ok = 1; seen = 0;
    for (int n = 0; n < 20 && !seen; n++) begin
      @(negedge clk);
      if (d_rdata !== 16'h1234 || busy !== 1'b1) hold_ok = 0;
      if (i_done) seen = 1;
    end
    i_req = 1'b0;
    chk("fetch_seen", seen, 1);
    chk("d_rdata_busy_hold", hold_ok, 1);

    repeat (3) @(posedge clk);
    chk("scoreboard_empty", sbq.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
